// File: rtl/ising_axi_frontend_pkg.sv
// Shared types and constants for the AXI-lite front end of the Ising core.
package ising_axi_frontend_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT,
    W_ISSUE,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/ising_axi_frontend_if.sv
// AXI-lite slave channels plus the simple downstream strobe/handshake bus.
interface ising_axi_frontend_if;
  import ising_axi_frontend_pkg::*;

  logic              s_awvalid;
  logic              s_awready;
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_wvalid;
  logic              s_wready;
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_bvalid;
  logic              s_bready;
  logic [1:0]        s_bresp;
  logic              s_arvalid;
  logic              s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_rvalid;
  logic              s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;

  logic              wready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wdata;
  logic              arvalid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic              rvalid;
  logic              rready;
  logic              rresp;
  logic [DATA_W-1:0] rdata;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready, rvalid, rresp, rdata,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp, wready, wr_addr, wdata, arvalid_q, araddr_q, rready
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready, rvalid, rresp, rdata,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
           s_rdata, s_rresp, wready, wr_addr, wdata, arvalid_q, araddr_q, rready
  );

endinterface

// File: rtl/ising_axi_frontend.sv
// AXI-lite slave front end: converts AW/W/B and AR/R channels into single-cycle
// downstream strobes, with a read timeout and late-response drain.
module ising_axi_frontend
  import ising_axi_frontend_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 axi_rstn,
  ising_axi_frontend_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);

  w_state_t          w_state;
  logic              aw_held;
  logic              w_held;
  logic              strb_ok;
  logic [ADDR_W-1:0] awaddr_h;
  logic [DATA_W-1:0] wdata_h;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_now;
  logic              w_now;
  logic              strb_now;
  logic [ADDR_W-1:0] addr_now;
  logic [DATA_W-1:0] data_now;

  r_state_t          r_state;
  logic              r_idle;
  logic [CNT_W-1:0]  rd_cnt;
  logic              ar_hs;

  // Address/data as seen this cycle, whether captured earlier or handshaking now
  assign aw_hs    = bus.s_awvalid & bus.s_awready;
  assign w_hs     = bus.s_wvalid & bus.s_wready;
  assign aw_now   = aw_held | aw_hs;
  assign w_now    = w_held | w_hs;
  assign strb_now = w_hs ? (bus.s_wstrb == {STRB_W{1'b1}}) : strb_ok;
  assign addr_now = aw_hs ? bus.s_awaddr : awaddr_h;
  assign data_now = w_hs ? bus.s_wdata : wdata_h;

  // Write path: collect AW and W in any order, strobe downstream, respond on B
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      w_state       <= W_COLLECT;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      strb_ok       <= 1'b0;
      awaddr_h      <= '0;
      wdata_h       <= '0;
      bus.s_awready <= 1'b0;
      bus.s_wready  <= 1'b0;
      bus.s_bvalid  <= 1'b0;
      bus.s_bresp   <= RESP_OKAY;
      bus.wready    <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wdata     <= '0;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (aw_hs) begin
            aw_held  <= 1'b1;
            awaddr_h <= bus.s_awaddr;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_h <= bus.s_wdata;
            strb_ok <= (bus.s_wstrb == {STRB_W{1'b1}});
          end
          if (aw_now && w_now) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            bus.s_awready <= 1'b0;
            bus.s_wready  <= 1'b0;
            if (strb_now) begin
              w_state     <= W_ISSUE;
              bus.wready  <= 1'b1;
              bus.wr_addr <= addr_now;
              bus.wdata   <= data_now;
            end else begin
              // partial writes are refused without touching downstream
              w_state      <= W_RESP;
              bus.s_bvalid <= 1'b1;
              bus.s_bresp  <= RESP_SLVERR;
            end
          end else begin
            bus.s_awready <= ~aw_now;
            bus.s_wready  <= ~w_now;
          end
        end
        W_ISSUE: begin
          bus.wready   <= 1'b0;
          bus.s_bvalid <= 1'b1;
          bus.s_bresp  <= RESP_OKAY;
          w_state      <= W_RESP;
        end
        W_RESP: begin
          if (bus.s_bready) begin
            bus.s_bvalid  <= 1'b0;
            bus.s_awready <= 1'b1;
            bus.s_wready  <= 1'b1;
            w_state       <= W_COLLECT;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Read handshakes; a late downstream response seen while idle is drained
  assign ar_hs         = bus.s_arvalid & bus.s_arready;
  assign bus.s_arready = r_idle & ~bus.rvalid;
  assign bus.rready    = (r_state == R_WAIT) | (r_idle & bus.rvalid);

  // Read path: issue strobe, wait for downstream with timeout, hold R response
  always_ff @(posedge clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      r_state       <= R_IDLE;
      r_idle        <= 1'b0;
      rd_cnt        <= '0;
      bus.arvalid_q <= 1'b0;
      bus.araddr_q  <= '0;
      bus.s_rvalid  <= 1'b0;
      bus.s_rdata   <= '0;
      bus.s_rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            bus.araddr_q  <= bus.s_araddr;
            bus.arvalid_q <= 1'b1;
            r_idle        <= 1'b0;
            r_state       <= R_ISSUE;
          end else begin
            r_idle <= 1'b1;
          end
        end
        R_ISSUE: begin
          bus.arvalid_q <= 1'b0;
          rd_cnt        <= '0;
          r_state       <= R_WAIT;
        end
        R_WAIT: begin
          if (bus.rvalid) begin
            bus.s_rdata  <= bus.rdata;
            bus.s_rresp  <= {bus.rresp, 1'b0};
            bus.s_rvalid <= 1'b1;
            r_state      <= R_RESP;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            bus.s_rdata  <= '0;
            bus.s_rresp  <= RESP_SLVERR;
            bus.s_rvalid <= 1'b1;
            r_state      <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end
        R_RESP: begin
          if (bus.s_rready) begin
            bus.s_rvalid <= 1'b0;
            r_idle       <= 1'b1;
            r_state      <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
